display_scan: RTL

Four-digit time-multiplexed scanner for the board's common-anode 7-segment display. It latches a 16-bit hex value, then cycles through the four digits, presenting one nibble per slot to the downstream `display7` hex-to-segment decoder (`in[3:0]`) and driving the active-low anode lines. The value is double-buffered so the display never shows a mix of old and new digits within a frame. Each digit slot opens with an anti-ghosting blank, and leading zeros can optionally be suppressed.

---
 rtl/display_scan.sv | 120 ++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// display_scan: four-digit time-multiplexed driver for a common-anode 7-segment display.
// A 16-bit value is captured into a shadow register and moved into the displayed
// register only at frame boundaries, so a frame never mixes old and new digits.
// Each digit slot opens with an all-anodes-off blank window. Leading zeros can be
// suppressed.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   value      : 16-bit hex value, nibble k -> digit k (digit 0 rightmost)
//   load       : single-cycle capture strobe for value
//   dp_en      : per-digit decimal point enable (live)
//   lz_en      : leading-zero suppression enable (live)
//   digit      : nibble for the current slot (registered)
//   dp_n       : active-low decimal point for the current slot (registered)
//   an         : active-low anode enables (registered)
//   frame_done : one-cycle pulse after each completed frame (registered)
module display_scan #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_en,
  input  logic        lz_en,
  output logic [3:0]  digit,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] CNT_MAX   = '1;
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [3:0]       digit_q, digit_d;
  logic             dp_n_q, dp_n_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             frame_end;
  logic             suppress;
  logic [3:0]       nib_sh;

  assign nib_sh    = {idx_q, 2'b00};
  assign frame_end = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
  // Digit k is dark when it and every more significant nibble are zero; digit 0 never.
  assign suppress  = lz_en && (idx_q != 2'd0) && ((disp_q >> nib_sh) == 16'h0000);

  // Next-state: prescaler, digit index, double-buffered value, registered outputs.
  always_comb begin
    cnt_d        = cnt_q + DIV_W'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    digit_d      = disp_q[nib_sh +: 4];
    dp_n_d       = ~dp_en[idx_q];
    an_d         = ~(4'b0001 << idx_q);
    frame_done_d = frame_end;

    if (cnt_q == CNT_MAX) begin
      idx_d = idx_q + 2'd1;
    end

    // A load on the boundary bypasses the shadow so it shows in the very next frame.
    if (load) begin
      shadow_d = value;
      if (frame_end) begin
        disp_d    = value;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (frame_end && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    if ((cnt_q < BLANK_LIM) || suppress) begin
      an_d = 4'b1111;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      disp_q       <= 16'h0000;
      pending_q    <= 1'b0;
      digit_q      <= 4'h0;
      dp_n_q       <= 1'b1;
      an_q         <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      digit_q      <= digit_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit      = digit_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
